// File: rtl/wb_arbiter.sv
// Writeback arbiter: per-unit result FIFOs feeding one register-file write port,
// granted round-robin, with a scoreboard release pulse for every granted entry.
module wb_arbiter #(
  parameter int DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [2:0]  fu_wb_valid,
  output logic [2:0]  fu_wb_ready,
  input  logic [14:0] fu_wb_regdest,
  input  logic [2:0]  fu_wb_writereg,
  input  logic [95:0] fu_wb_data,
  output logic        wb_reg_we,
  output logic [4:0]  wb_reg_addr,
  output logic [31:0] wb_reg_data,
  output logic        wb_sb_clr,
  output logic [4:0]  wb_sb_addr,
  output logic [1:0]  wb_sb_fununit,
  output logic        wb_busy
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic        writereg;
    logic [4:0]  regdest;
    logic [31:0] data;
  } entry_t;

  logic [2:0]   push;
  logic [2:0]   pop;
  logic [2:0]   nonempty;
  entry_t [2:0] head;

  logic [1:0] last;
  logic [1:0] winner;
  logic       grant;
  entry_t     sel;

  for (genvar i = 0; i < 3; i++) begin : g_fifo
    entry_t        mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    // Ready looks only at the current count, so a full FIFO refuses even while it is being popped.
    assign fu_wb_ready[i] = (count < FULL) & reset;
    assign push[i]        = fu_wb_valid[i] & fu_wb_ready[i];
    assign nonempty[i]    = (count != '0);
    assign head[i]        = mem[rd_ptr];

    always_ff @(posedge clock) begin
      if (push[i]) begin
        mem[wr_ptr] <= {fu_wb_writereg[i], fu_wb_regdest[5*i +: 5], fu_wb_data[32*i +: 32]};
      end
    end

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push[i]) begin
          wr_ptr <= wr_ptr + PW'(1);
        end
        if (pop[i]) begin
          rd_ptr <= rd_ptr + PW'(1);
        end
        case ({push[i], pop[i]})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Search starts just after the last winner; when last is 0 the order is 1, 2, 0.
  always_comb begin
    winner = 2'd0;
    case (last)
      2'd0: begin
        if (nonempty[1])      winner = 2'd1;
        else if (nonempty[2]) winner = 2'd2;
        else                  winner = 2'd0;
      end
      2'd1: begin
        if (nonempty[2])      winner = 2'd2;
        else if (nonempty[0]) winner = 2'd0;
        else                  winner = 2'd1;
      end
      default: begin
        if (nonempty[0])      winner = 2'd0;
        else if (nonempty[1]) winner = 2'd1;
        else                  winner = 2'd2;
      end
    endcase
    grant = |nonempty;
    pop   = grant ? (3'b001 << winner) : 3'b000;
    sel   = head[winner];
  end

  assign wb_busy = |nonempty;

  // Release is pulsed even for non-writing or register-0 entries; address and data hold when idle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last          <= 2'd2;
      wb_reg_we     <= 1'b0;
      wb_reg_addr   <= 5'd0;
      wb_reg_data   <= 32'd0;
      wb_sb_clr     <= 1'b0;
      wb_sb_addr    <= 5'd0;
      wb_sb_fununit <= 2'd0;
    end else if (grant) begin
      last          <= winner;
      wb_reg_we     <= sel.writereg & (sel.regdest != 5'd0);
      wb_reg_addr   <= sel.regdest;
      wb_reg_data   <= sel.data;
      wb_sb_clr     <= 1'b1;
      wb_sb_addr    <= sel.regdest;
      wb_sb_fununit <= winner + 2'd1;
    end else begin
      wb_reg_we     <= 1'b0;
      wb_sb_clr     <= 1'b0;
      wb_sb_fununit <= 2'd0;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: a queue-based model checked every cycle, plus
// hand-computed expectations for the directed scenarios.
module tb_wb_arbiter;

  localparam int DEPTH = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  fu_wb_valid = '0;
  logic [14:0] fu_wb_regdest = '0;
  logic [2:0]  fu_wb_writereg = '0;
  logic [95:0] fu_wb_data = '0;
  logic [2:0]  fu_wb_ready;
  logic        wb_reg_we;
  logic [4:0]  wb_reg_addr;
  logic [31:0] wb_reg_data;
  logic        wb_sb_clr;
  logic [4:0]  wb_sb_addr;
  logic [1:0]  wb_sb_fununit;
  logic        wb_busy;

  int checks = 0;
  int errors = 0;

  wb_arbiter #(.DEPTH(DEPTH)) dut (
    .clock         (clock),
    .reset         (reset),
    .fu_wb_valid   (fu_wb_valid),
    .fu_wb_ready   (fu_wb_ready),
    .fu_wb_regdest (fu_wb_regdest),
    .fu_wb_writereg(fu_wb_writereg),
    .fu_wb_data    (fu_wb_data),
    .wb_reg_we     (wb_reg_we),
    .wb_reg_addr   (wb_reg_addr),
    .wb_reg_data   (wb_reg_data),
    .wb_sb_clr     (wb_sb_clr),
    .wb_sb_addr    (wb_sb_addr),
    .wb_sb_fununit (wb_sb_fununit),
    .wb_busy       (wb_busy)
  );

  always #5 clock = ~clock;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // One bench step: wait for an edge, then drive the inputs for the following edge.
  task automatic apply_stimulus(input logic [2:0] v, input logic [14:0] rd, input logic [2:0] wr, input logic [95:0] d);
    @(posedge clock);
    #2;
    fu_wb_valid    = v;
    fu_wb_regdest  = rd;
    fu_wb_writereg = wr;
    fu_wb_data     = d;
  endtask

  task automatic idle(input int n);
    repeat (n) apply_stimulus('0, '0, '0, '0);
  endtask

  // Model: all buffered results live in one arrival-ordered queue tagged with their unit.
  typedef struct {
    int          unit;
    logic        wr;
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        mq[$];
  int          m_last = 2;
  logic        m_we = 1'b0;
  logic [4:0]  m_addr = '0;
  logic [31:0] m_data = '0;
  logic        m_clr = 1'b0;
  logic [4:0]  m_sbaddr = '0;
  logic [1:0]  m_fu = '0;
  int          pre [3];
  int          win;
  int          found;
  ent_t        e;
  logic [2:0]  exp_ready;

  function automatic int occ(input int u);
    int n = 0;
    foreach (mq[j]) if (mq[j].unit == u) n++;
    return n;
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      mq.delete();
      m_last = 2;
      m_we = 1'b0; m_addr = '0; m_data = '0;
      m_clr = 1'b0; m_sbaddr = '0; m_fu = '0;
    end else begin
      for (int u = 0; u < 3; u++) pre[u] = occ(u);
      win = -1;
      for (int k = 1; k <= 3; k++) begin
        if (win < 0 && pre[(m_last + k) % 3] > 0) win = (m_last + k) % 3;
      end
      if (win >= 0) begin
        found = -1;
        for (int j = 0; j < mq.size(); j++) if (found < 0 && mq[j].unit == win) found = j;
        e = mq[found];
        mq.delete(found);
        m_we     = e.wr && (e.rd != 5'd0);
        m_addr   = e.rd;
        m_data   = e.data;
        m_clr    = 1'b1;
        m_sbaddr = e.rd;
        m_fu     = 2'(win + 1);
        m_last   = win;
      end else begin
        m_we  = 1'b0;
        m_clr = 1'b0;
        m_fu  = 2'd0;
      end
      for (int u = 0; u < 3; u++) begin
        if (fu_wb_valid[u] && pre[u] < DEPTH) begin
          e.unit = u;
          e.wr   = fu_wb_writereg[u];
          e.rd   = fu_wb_regdest[5*u +: 5];
          e.data = fu_wb_data[32*u +: 32];
          mq.push_back(e);
        end
      end
    end
  end

  always @(negedge clock) begin
    for (int u = 0; u < 3; u++) exp_ready[u] = reset && (occ(u) < DEPTH);
    check_output("ready", 32'(fu_wb_ready), 32'(exp_ready));
    check_output("busy", 32'(wb_busy), 32'(mq.size() != 0));
    check_output("reg_we", 32'(wb_reg_we), 32'(m_we));
    check_output("reg_addr", 32'(wb_reg_addr), 32'(m_addr));
    check_output("reg_data", wb_reg_data, m_data);
    check_output("sb_clr", 32'(wb_sb_clr), 32'(m_clr));
    check_output("sb_addr", 32'(wb_sb_addr), 32'(m_sbaddr));
    check_output("sb_fununit", 32'(wb_sb_fununit), 32'(m_fu));
  end

  int   k;
  logic hs;

  initial begin
    #1;
    check_output("rst_ready", 32'(fu_wb_ready), 32'd0);
    check_output("rst_busy", 32'(wb_busy), 32'd0);
    check_output("rst_clr", 32'(wb_sb_clr), 32'd0);
    check_output("rst_data", wb_reg_data, 32'd0);
    repeat (3) @(posedge clock);
    #2 reset = 1'b1;
    idle(2);

    // Single result from unit 1.
    apply_stimulus(3'b010, {5'd0, 5'd7, 5'd0}, 3'b010, {32'd0, 32'hDEADBEEF, 32'd0});
    apply_stimulus('0, '0, '0, '0);
    @(posedge clock);
    @(negedge clock);
    check_output("single_we", 32'(wb_reg_we), 32'd1);
    check_output("single_addr", 32'(wb_reg_addr), 32'd7);
    check_output("single_data", wb_reg_data, 32'hDEADBEEF);
    check_output("single_clr", 32'(wb_sb_clr), 32'd1);
    check_output("single_sbaddr", 32'(wb_sb_addr), 32'd7);
    check_output("single_fu", 32'(wb_sb_fununit), 32'd2);
    @(negedge clock);
    check_output("single_pulse_end", 32'(wb_sb_clr), 32'd0);
    idle(2);

    // Fairness: all units continuously valid after a fresh reset.
    @(posedge clock); #2 reset = 1'b0;
    @(posedge clock); #2 reset = 1'b1;
    apply_stimulus(3'b111, {5'd3, 5'd2, 5'd1}, 3'b111, {32'h3333, 32'h2222, 32'h1111});
    @(posedge clock);
    @(posedge clock);
    for (int n = 0; n < 6; n++) begin
      @(negedge clock);
      check_output("fair_fu", 32'(wb_sb_fununit), 32'((n % 3) + 1));
      check_output("fair_addr", 32'(wb_sb_addr), 32'((n % 3) + 1));
      @(posedge clock);
    end
    idle(10);

    // Register 0 and non-writing results.
    apply_stimulus(3'b001, {10'd0, 5'd0}, 3'b001, {64'd0, 32'hAAAA0000});
    apply_stimulus(3'b001, {10'd0, 5'd5}, 3'b000, {64'd0, 32'hBBBB0005});
    apply_stimulus('0, '0, '0, '0);
    @(negedge clock);
    check_output("r0_we", 32'(wb_reg_we), 32'd0);
    check_output("r0_clr", 32'(wb_sb_clr), 32'd1);
    check_output("r0_sbaddr", 32'(wb_sb_addr), 32'd0);
    @(negedge clock);
    check_output("nowr_we", 32'(wb_reg_we), 32'd0);
    check_output("nowr_clr", 32'(wb_sb_clr), 32'd1);
    check_output("nowr_sbaddr", 32'(wb_sb_addr), 32'd5);
    idle(2);

    // Simultaneous push and pop on unit 0.
    apply_stimulus(3'b001, {10'd0, 5'd9}, 3'b001, {64'd0, 32'h9});
    apply_stimulus(3'b001, {10'd0, 5'd12}, 3'b001, {64'd0, 32'hC});
    apply_stimulus('0, '0, '0, '0);
    @(negedge clock);
    check_output("pp_ready0", 32'(fu_wb_ready[0]), 32'd1);
    check_output("pp_busy", 32'(wb_busy), 32'd1);
    check_output("pp_first", 32'(wb_sb_addr), 32'd9);
    @(negedge clock);
    check_output("pp_second", 32'(wb_sb_addr), 32'd12);
    check_output("pp_empty", 32'(wb_busy), 32'd0);
    idle(2);

    // Backpressure: units 0 and 1 hog, unit 2 offers three entries in order.
    @(posedge clock); #2 reset = 1'b0;
    @(posedge clock); #2 reset = 1'b1;
    apply_stimulus(3'b111, {5'd10, 5'd2, 5'd1}, 3'b111, {32'hC0, 32'h2222, 32'h1111});
    k = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (c == 2) check_output("hog_ready", 32'(fu_wb_ready), 32'h1);
      if (c == 4) begin
        check_output("hog_u2_addr", 32'(wb_sb_addr), 32'd10);
        check_output("hog_u2_fu", 32'(wb_sb_fununit), 32'd3);
      end
      hs = fu_wb_valid[2] & fu_wb_ready[2];
      @(posedge clock);
      #2;
      if (hs) k++;
      fu_wb_valid          = {k < 3, 2'b11};
      fu_wb_regdest[14:10] = 5'(10 + k);
      fu_wb_data[95:64]    = 32'hC0 + 32'(k);
    end
    check_output("hog_accepted", 32'(k), 32'd3);
    idle(10);

    // Mid-operation reset with two entries still buffered.
    apply_stimulus(3'b111, {5'd22, 5'd21, 5'd20}, 3'b111, {32'h22, 32'h21, 32'h20});
    apply_stimulus('0, '0, '0, '0);
    @(posedge clock);
    #2 reset = 1'b0;
    #1;
    check_output("mr_we", 32'(wb_reg_we), 32'd0);
    check_output("mr_addr", 32'(wb_reg_addr), 32'd0);
    check_output("mr_data", wb_reg_data, 32'd0);
    check_output("mr_clr", 32'(wb_sb_clr), 32'd0);
    check_output("mr_sbaddr", 32'(wb_sb_addr), 32'd0);
    check_output("mr_fu", 32'(wb_sb_fununit), 32'd0);
    check_output("mr_ready", 32'(fu_wb_ready), 32'd0);
    check_output("mr_busy", 32'(wb_busy), 32'd0);
    repeat (2) @(posedge clock);
    #2 reset = 1'b1;
    for (int n = 0; n < 6; n++) begin
      @(negedge clock);
      check_output("mr_no_release", 32'(wb_sb_clr), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
